// File: rtl/wb_arbiter.sv
// wb_arbiter: single-port regfile writeback arbiter; the pipe commit path wins over mul/div results.
// Define WB_ARB_STARVE_EN to add the MDU starvation detector (IDLE/WAIT/STARVED FSM) driving stall_req.
module wb_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        p_we,
    input  logic [4:0]  p_rd,
    input  logic [31:0] p_data,
    input  logic        m_valid,
    input  logic [4:0]  m_rd,
    input  logic [31:0] m_data,
    output logic        m_ready,
    output logic        we_o,
    output logic [4:0]  rd_o,
    output logic [31:0] wdata_o,
    output logic        stall_req
);

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve_max
        $error("wb_arbiter: STARVE_MAX must be within 1..15");
    end

    logic              p_live_p0;
    logic              m_xfer_p0;
    logic              vld_p0;
    logic [ADDR_W-1:0] rd_p0;
    logic [DATA_W-1:0] data_p0;

    // Writes to x0 are not real requests, so they never block the MDU.
    assign p_live_p0 = p_we && (p_rd != '0);
    assign m_ready   = nrst && !p_live_p0;
    assign m_xfer_p0 = m_valid && m_ready;

    always_comb begin
        vld_p0  = 1'b0;
        rd_p0   = m_rd;
        data_p0 = m_data;
        if (p_live_p0) begin
            vld_p0  = 1'b1;
            rd_p0   = p_rd;
            data_p0 = p_data;
        end else if (m_xfer_p0 && (m_rd != '0)) begin
            vld_p0 = 1'b1;
        end
    end

    // Stage p0 -> p1: registered regfile write port
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            we_o    <= 1'b0;
            rd_o    <= '0;
            wdata_o <= '0;
        end else begin
            we_o <= vld_p0;
            if (vld_p0) begin
                rd_o    <= rd_p0;
                wdata_o <= data_p0;
            end
        end
    end

`ifdef WB_ARB_STARVE_EN
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        STARVED = 2'd2
    } starve_state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    starve_state_t state_q;
    starve_state_t state_d;
    logic [3:0]    blk_cnt;
    logic [3:0]    blk_cnt_d;

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q   <= IDLE;
            blk_cnt   <= '0;
            stall_req <= 1'b0;
        end else begin
            state_q   <= state_d;
            blk_cnt   <= blk_cnt_d;
            stall_req <= (state_d == STARVED);
        end
    end

    // Past the first branch the MDU is valid and not transferring, i.e. blocked.
    always_comb begin
        state_d   = state_q;
        blk_cnt_d = blk_cnt;
        if (m_xfer_p0 || !m_valid) begin
            state_d   = IDLE;
            blk_cnt_d = '0;
        end else begin
            blk_cnt_d = sat_inc4(blk_cnt);
            case (state_q)
                IDLE, WAIT: state_d = (blk_cnt_d >= STARVE_LIM) ? STARVED : WAIT;
                STARVED:    state_d = STARVED;
                default:    state_d = IDLE;
            endcase
        end
    end
`else
    assign stall_req = 1'b0;
`endif

endmodule
